// File: rtl/add_arbiter.sv
// Four-requester round-robin arbiter feeding a two-stage adder pipeline.
// S1 captures the granted operand pair; OUT holds the truncated sum until consumed.
module add_arbiter #(
    parameter int W = 10,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_sum,
    output logic [1:0]     rsp_id,
    output logic           busy
);

    logic [1:0]   p;
    logic         s1_valid;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    logic [1:0]   s1_id;
    logic         out_valid;
    logic [W-1:0] out_sum;
    logic [1:0]   out_id;

    logic         out_adv;
    logic         can_grant;
    logic         found;
    logic [1:0]   winner;
    logic         grant;

    always_comb begin
        found  = 1'b0;
        winner = p;
        for (int k = 0; k < N; k++) begin
            if (!found && req_valid[p + 2'(k)]) begin
                found  = 1'b1;
                winner = p + 2'(k);
            end
        end
    end

    // A grant needs room in S1 this cycle, which chains back to OUT draining.
    assign out_adv   = s1_valid && (!out_valid || rsp_ready);
    assign can_grant = !rst && (!s1_valid || out_adv);
    assign grant     = can_grant && found;
    assign req_ready = grant ? ({{(N-1){1'b0}}, 1'b1} << winner) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            p         <= 2'd0;
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_id     <= 2'd0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_id    <= 2'd0;
        end else begin
            if (out_adv) begin
                out_valid <= 1'b1;
                out_sum   <= s1_a + s1_b;
                out_id    <= s1_id;
            end else if (rsp_ready) begin
                out_valid <= 1'b0;
            end

            if (grant) begin
                s1_valid <= 1'b1;
                s1_a     <= req_a[winner*W +: W];
                s1_b     <= req_b[winner*W +: W];
                s1_id    <= winner;
                p        <= winner + 2'd1;
            end else if (out_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid = out_valid;
    assign rsp_sum   = out_sum;
    assign rsp_id    = out_id;
    assign busy      = s1_valid || out_valid;

endmodule
